// File: rtl/bnn_layer_ctrl.sv
// -----------------------------------------------------------------------------
// bnn_layer_ctrl
//
// Command-driven controller and datapath for one binary fully-connected BNN
// layer. Command bytes arrive on an rx byte stream; weights and the input
// vector are held in registers; neuron outputs are computed one per cycle as
// popcount(~(x ^ w[j])) >= threshold and returned on a tx byte stream.
//
// Commands (accepted in IDLE only):
//   0x01 LOAD_W  : N_OUT*N_IN/8 weight bytes follow, byte j*(N_IN/8)+k -> w[j][8k+:8]
//   0x02 LOAD_X  : N_IN/8 input bytes follow, byte k -> x[8k+:8]
//   0x03 RUN     : compute all neurons, then send N_OUT/8 result bytes
//   0x04 STATUS  : send {5'b0, err, x_loaded, w_loaded}; err clears on its handshake
//   0x05 LOAD_T  : N_OUT per-neuron threshold bytes (BNN_THRESH_LOAD_EN only)
//   other        : sets the sticky err flag
//
// Optional feature macro: BNN_THRESH_LOAD_EN
//   When defined, adds a per-neuron 8-bit threshold array t[] (reset to
//   THRESH), the LOAD_T command/state, and COMPUTE compares against t[idx].
//   When undefined, every neuron uses the fixed THRESH and 0x05 is unknown.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   rx_data   in   [7:0] command/payload byte
//   rx_valid  in   rx_data valid
//   rx_ready  out  controller accepts an rx byte this cycle (decoded from state)
//   tx_data   out  [7:0] outgoing byte
//   tx_valid  out  tx_data valid
//   tx_ready  in   sink accepts the tx byte
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the last result byte of a RUN transfers
//
// Handshake rule (both streams): a byte transfers on a rising clk edge where
// valid and ready are both high. The producer keeps data stable and valid
// asserted until that edge; the consumer may drop ready at any time.
// -----------------------------------------------------------------------------
module bnn_layer_ctrl #(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 8,
  parameter int THRESH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int NB_IN  = N_IN / 8;
  localparam int NB_OUT = N_OUT / 8;
  localparam int PC_W   = $clog2(N_IN + 1);
  // Compare width covers both the popcount and any 8-bit threshold, so a
  // threshold above N_IN simply never fires instead of wrapping.
  localparam int CMP_W  = ((PC_W > 8) ? PC_W : 8) + 1;
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int BC_W   = $clog2(NB_IN + NB_OUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_OUT - 1);
  localparam logic [BC_W-1:0]  BC_LAST_IN  = BC_W'(NB_IN - 1);
  localparam logic [BC_W-1:0]  BC_LAST_OUT = BC_W'(NB_OUT - 1);

  localparam logic [7:0] CMD_LOAD_W = 8'h01;
  localparam logic [7:0] CMD_LOAD_X = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;
`ifdef BNN_THRESH_LOAD_EN
  localparam logic [7:0] CMD_LOAD_T = 8'h05;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
`ifdef BNN_THRESH_LOAD_EN
    ST_LOAD_T,
`endif
    ST_COMPUTE,
    ST_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   w_q [N_OUT];
  logic [N_IN-1:0]   w_d [N_OUT];
  logic [N_IN-1:0]   x_q, x_d;
  logic [N_OUT-1:0]  y_q, y_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              w_loaded_q, w_loaded_d;
  logic              x_loaded_q, x_loaded_d;
  logic              err_q, err_d;
  // Selects what SEND transmits: one status byte, or the result vector.
  logic              send_status_q, send_status_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef BNN_THRESH_LOAD_EN
  logic [7:0]        t_q [N_OUT];
  logic [7:0]        t_d [N_OUT];
`endif

  logic              rx_fire;
  logic              tx_fire;
  logic [7:0]        status_byte;
  logic [BC_W-1:0]   bc_next;
  logic [IDX_W-1:0]  idx_next;
  logic [CMP_W-1:0]  pop_ext;
  logic [CMP_W-1:0]  thr_ext;
  logic              neuron_fires;

  function automatic logic [PC_W-1:0] popcount(input logic [N_IN-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // rx_ready depends on state only, never on rx_valid.
  always_comb begin
    rx_ready = (state_q == ST_IDLE)   ||
`ifdef BNN_THRESH_LOAD_EN
               (state_q == ST_LOAD_T) ||
`endif
               (state_q == ST_LOAD_W) ||
               (state_q == ST_LOAD_X);
  end

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid_q & tx_ready;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    x_d           = x_q;
    y_d           = y_q;
    idx_d         = idx_q;
    byte_cnt_d    = byte_cnt_q;
    w_loaded_d    = w_loaded_q;
    x_loaded_d    = x_loaded_q;
    err_d         = err_q;
    send_status_d = send_status_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    done_d        = 1'b0;
`ifdef BNN_THRESH_LOAD_EN
    t_d           = t_q;
`endif

    status_byte  = {5'b0, err_q, x_loaded_q, w_loaded_q};
    bc_next      = byte_cnt_q + BC_W'(1);
    idx_next     = idx_q + IDX_W'(1);
    pop_ext      = CMP_W'(popcount(~(x_q ^ w_q[idx_q])));
`ifdef BNN_THRESH_LOAD_EN
    thr_ext      = CMP_W'(t_q[idx_q]);
`else
    thr_ext      = CMP_W'(THRESH);
`endif
    neuron_fires = (pop_ext >= thr_ext);

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_LOAD_W: begin
              w_loaded_d = 1'b0;
              idx_d      = '0;
              byte_cnt_d = '0;
              state_d    = ST_LOAD_W;
            end
            CMD_LOAD_X: begin
              x_loaded_d = 1'b0;
              byte_cnt_d = '0;
              state_d    = ST_LOAD_X;
            end
            CMD_RUN: begin
              if (w_loaded_q && x_loaded_q) begin
                idx_d   = '0;
                state_d = ST_COMPUTE;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_STATUS: begin
              send_status_d = 1'b1;
              byte_cnt_d    = '0;
              state_d       = ST_SEND;
            end
`ifdef BNN_THRESH_LOAD_EN
            CMD_LOAD_T: begin
              idx_d   = '0;
              state_d = ST_LOAD_T;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end

      // Weight bytes walk k (byte within a row) fastest, then j (neuron row).
      ST_LOAD_W: begin
        if (rx_fire) begin
          w_d[idx_q][8*byte_cnt_q +: 8] = rx_data;
          if (byte_cnt_q == BC_LAST_IN) begin
            byte_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              w_loaded_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              idx_d = idx_next;
            end
          end else begin
            byte_cnt_d = bc_next;
          end
        end
      end

      ST_LOAD_X: begin
        if (rx_fire) begin
          x_d[8*byte_cnt_q +: 8] = rx_data;
          if (byte_cnt_q == BC_LAST_IN) begin
            byte_cnt_d = '0;
            x_loaded_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            byte_cnt_d = bc_next;
          end
        end
      end

`ifdef BNN_THRESH_LOAD_EN
      ST_LOAD_T: begin
        if (rx_fire) begin
          t_d[idx_q] = rx_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_next;
          end
        end
      end
`endif

      ST_COMPUTE: begin
        y_d[idx_q] = neuron_fires;
        if (idx_q == IDX_LAST) begin
          idx_d         = '0;
          byte_cnt_d    = '0;
          send_status_d = 1'b0;
          state_d       = ST_SEND;
        end else begin
          idx_d = idx_next;
        end
      end

      // The first byte is loaded one cycle after entering SEND, so the final
      // y bit written on the last COMPUTE edge is already visible.
      ST_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = send_status_q ? status_byte : y_q[8*byte_cnt_q +: 8];
        end else if (tx_fire) begin
          if (send_status_q) begin
            err_d         = 1'b0;
            send_status_d = 1'b0;
            tx_valid_d    = 1'b0;
            state_d       = ST_IDLE;
          end else if (byte_cnt_q == BC_LAST_OUT) begin
            done_d     = 1'b1;
            byte_cnt_d = '0;
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            byte_cnt_d = bc_next;
            tx_data_d  = y_q[8*bc_next +: 8];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int j = 0; j < N_OUT; j++) begin
        w_q[j] <= '0;
      end
      x_q           <= '0;
      y_q           <= '0;
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      w_loaded_q    <= 1'b0;
      x_loaded_q    <= 1'b0;
      err_q         <= 1'b0;
      send_status_q <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BNN_THRESH_LOAD_EN
      for (int j = 0; j < N_OUT; j++) begin
        t_q[j] <= 8'(THRESH);
      end
`endif
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      x_q           <= x_d;
      y_q           <= y_d;
      idx_q         <= idx_d;
      byte_cnt_q    <= byte_cnt_d;
      w_loaded_q    <= w_loaded_d;
      x_loaded_q    <= x_loaded_d;
      err_q         <= err_d;
      send_status_q <= send_status_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
`ifdef BNN_THRESH_LOAD_EN
      t_q           <= t_d;
`endif
    end
  end

endmodule

// File: tb/tb_bnn_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bnn_layer_ctrl
//
// Bench for bnn_layer_ctrl (default build, fixed THRESH). A behavioural model
// holds the weights, input vector and flags as plain arrays and derives each
// result bit directly from popcount-of-XNOR against THRESH. Expected tx bytes
// go into exp_q; a negedge monitor pops them on every tx transfer and also
// tracks where the done pulse must appear.
// -----------------------------------------------------------------------------
module tb_bnn_layer_ctrl;

  localparam int N_IN   = 16;
  localparam int N_OUT  = 8;
  localparam int THRESH = 8;
  localparam int NB_IN  = N_IN / 8;
  localparam int NB_OUT = N_OUT / 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       done;

  bnn_layer_ctrl #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .THRESH (THRESH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  // tx_ready is owned by this one process; tests steer it via the two flags.
  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  // {is_last_byte_of_run, data}
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  logic [N_IN-1:0] m_w [N_OUT];
  logic [N_IN-1:0] m_x;
  bit m_wl, m_xl, m_err;

  task automatic model_reset();
    for (int j = 0; j < N_OUT; j++) m_w[j] = '0;
    m_x   = '0;
    m_wl  = 1'b0;
    m_xl  = 1'b0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_y_byte(input int b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = ($countones(~(m_w[8*b+i] ^ m_x)) >= THRESH);
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic done_exp = 1'b0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      check("done", done, done_exp);
      done_exp = 1'b0;
      if (tx_valid && tx_ready) begin
        check("tx_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e[7:0]);
          done_exp = e[8];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int n);
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bit took = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!took && waited < 200) begin
      took = rx_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    rx_valid = 1'b0;
    check("rx_accept", took, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", busy, 0);
  endtask

  // mode 0: all 0xFF, mode 1: even rows 0xFF / odd rows 0x00, mode 2: random
  task automatic load_w(input int mode);
    logic [7:0] b;
    m_wl = 1'b0;
    send_byte(8'h01);
    for (int j = 0; j < N_OUT; j++) begin
      for (int k = 0; k < NB_IN; k++) begin
        case (mode)
          0:       b = 8'hFF;
          1:       b = (j % 2 == 0) ? 8'hFF : 8'h00;
          default: b = 8'($urandom_range(0, 255));
        endcase
        m_w[j][8*k +: 8] = b;
        send_byte(b);
      end
    end
    m_wl = 1'b1;
  endtask

  task automatic load_x(input logic [N_IN-1:0] v);
    m_xl = 1'b0;
    send_byte(8'h02);
    for (int k = 0; k < NB_IN; k++) begin
      m_x[8*k +: 8] = v[8*k +: 8];
      send_byte(v[8*k +: 8]);
    end
    m_xl = 1'b1;
  endtask

  task automatic do_status();
    exp_q.push_back({1'b0, 5'b0, m_err, m_xl, m_wl});
    m_err = 1'b0;
    send_byte(8'h04);
    drain();
  endtask

  task automatic push_run_result();
    for (int b = 0; b < NB_OUT; b++) begin
      exp_q.push_back({1'(b == NB_OUT - 1), model_y_byte(b)});
    end
  endtask

  task automatic wait_first_tx(output int n);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_run();
    int n;
    bit saw;
    if (m_wl && m_xl) begin
      push_run_result();
      send_byte(8'h03);
      wait_first_tx(n);
      check("run_latency", n, N_OUT + 1);
      drain();
    end else begin
      m_err = 1'b1;
      send_byte(8'h03);
      saw = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (tx_valid) saw = 1'b1;
      end
      check("run_no_tx", saw, 0);
    end
  endtask

  task automatic do_bad(input logic [7:0] b);
    m_err = 1'b1;
    send_byte(b);
    repeat (3) @(posedge clk);
    #1;
    check("bad_no_tx", tx_valid, 0);
    check("bad_idle", busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int r;
    model_reset();
    apply_reset(2);

    // reset state
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_ready", rx_ready, 1);
    do_status();

    // RUN before any load: error, no tx, err clears after one STATUS
    do_run();
    do_status();
    do_status();

    // all-match layer
    load_w(0);
    load_x(16'hFFFF);
    do_run();

    // mixed weights: 0x55 then 0xAA
    load_w(1);
    load_x(16'hFFFF);
    do_run();
    load_x(16'h0000);
    do_run();

    // unknown command sets err, reported once
    do_bad(8'h07);
    do_status();
    do_status();

    // backpressure during SEND
    load_x(16'($urandom_range(0, 65535)));
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_run_result();
    send_byte(8'h03);
    wait_first_tx(n);
    check("bp_latency", n, N_OUT + 1);
    repeat (5) begin
      check("bp_valid", tx_valid, 1);
      check("bp_data", tx_data, exp_q[0][7:0]);
      check("bp_rx_ready", rx_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_done", done, 0);
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    drain();

    // reset in the middle of a weight load
    send_byte(8'h01);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)));
    apply_reset(1);
    check("midrst_busy", busy, 0);
    check("midrst_rx_ready", rx_ready, 1);
    check("midrst_tx_valid", tx_valid, 0);
    do_status();
    do_run();
    do_status();

    // randomized command mix with random tx backpressure
    rand_ready = 1'b1;
    load_w(2);
    load_x(16'($urandom_range(0, 65535)));
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: load_w(2);
        1: load_x(16'($urandom_range(0, 65535)));
        2, 3: do_run();
        4: do_status();
        default: begin
          r = $urandom_range(0, 250);
          do_bad((r == 0) ? 8'h00 : 8'(r + 5));
        end
      endcase
    end
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_status();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_layer_ctrl.md
Name: bnn_layer_ctrl

Overview:
Command-driven controller and datapath for one binary fully-connected BNN layer. It sits between the UART byte stream and the top-level pins. It accepts command bytes on an rx valid/ready stream, stores weights and the input vector in registers, and computes XNOR-popcount-threshold outputs one neuron per cycle. Results and status return on a tx valid/ready byte stream.

Parameters:
N_IN, 16, input vector width in bits; must be a multiple of 8 and no greater than 255.
N_OUT, 8, neuron count; must be a multiple of 8.
THRESH, 8, fixed firing threshold. A neuron fires when popcount is greater than or equal to THRESH.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rx_data  input  8  incoming command/payload byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  controller accepts rx byte this cycle
tx_data  output  8  outgoing byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts tx byte
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on handshake of the last tx byte of a RUN

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous and active-high.
- Handshakes:
  - A byte transfers on a rising edge where valid and ready are both high.
  - tx_data is held stable while tx_valid is high and tx_ready is low.
  - rx_ready is decoded from state only. It is 1 in IDLE, LOAD_W, LOAD_X and LOAD_T, and 0 in COMPUTE and SEND.
- States: IDLE, LOAD_W, LOAD_X, LOAD_T (optional feature only), COMPUTE, SEND.
- Commands, accepted in IDLE:
  - 0x01 LOAD_W: clear w_loaded, then go to LOAD_W for N_OUT*N_IN/8 bytes.
    - Byte index j*(N_IN/8)+k is written to w[j][8k+7:8k].
    - Each byte is written on its handshake.
    - After the last byte: set w_loaded, go to IDLE.
  - 0x02 LOAD_X: clear x_loaded, then go to LOAD_X for N_IN/8 bytes.
    - Byte k is written to x[8k+7:8k].
    - After the last byte: set x_loaded, go to IDLE.
  - 0x03 RUN:
    - If w_loaded and x_loaded are both 1: go to COMPUTE with idx=0.
    - Otherwise: set err, stay in IDLE, send no tx.
  - 0x04 STATUS: go to SEND with one byte {5'b0, err, x_loaded, w_loaded}. err clears on that byte's handshake. STATUS does not pulse done.
  - Any other byte: set err, stay in IDLE.
- COMPUTE:
  - Each cycle, y[idx] <= (popcount(~(x ^ w[idx])) >= THRESH), then idx increments.
  - Popcount width is clog2(N_IN+1).
  - After idx = N_OUT-1, go to SEND.
- Latency: tx_valid first rises exactly N_OUT+1 cycles after the RUN accept edge.
- SEND:
  - Sends N_OUT/8 bytes, byte b = y[8b+7:8b].
  - tx_valid stays high until the final handshake. On that handshake go to IDLE and, for RUN only, pulse done.
- Load completion: there is no timeout. LOAD states wait indefinitely for remaining bytes. Bytes written so far stay written, but the loaded flag stays 0.
- Register contents: weights and input persist across RUNs. RUN does not clear x_loaded.
- Reset values, including reset mid-operation:
  - state=IDLE; w, x, y, idx, byte counter = 0.
  - w_loaded=0, x_loaded=0, err=0.
  - tx_valid=0, tx_data=0, done=0, busy=0.
  - rx_ready=1 on the first cycle after reset.
  - Any in-progress load, compute or send is aborted with no further tx bytes.
- err is sticky. It is cleared only by rst or by a STATUS byte handshake. A new error arriving on the same cycle as that handshake cannot happen, because rx_ready=0 in SEND.

Optional Feature:
- Macro: BNN_THRESH_LOAD_EN
- Defined:
  - Adds an N_OUT x 8-bit threshold register array t[], reset to THRESH.
  - Command 0x05 goes to LOAD_T for N_OUT bytes. Byte j is written to t[j]. Then return to IDLE.
  - COMPUTE compares against t[idx] instead of THRESH.
- Undefined:
  - No t[] array and no LOAD_T state.
  - 0x05 is an unknown command and sets err.

Test Plan:
- Reset: drive rst for 2 cycles -> tx_valid=0, busy=0, done=0, rx_ready=1. Then STATUS (0x04) -> tx byte 0x00.
- Run before any load: after reset send RUN 0x03 -> no tx_valid for 20 cycles. STATUS -> 0x04. STATUS again -> 0x00.
- All-match layer (N_IN=16, N_OUT=8, THRESH=8):
  - Send 0x01 plus 16 bytes of 0xFF, then 0x02 0xFF 0xFF, then 0x03.
  - Required: tx_valid rises 9 cycles after the RUN accept, tx_data=0xFF, done pulses for 1 cycle.
- Mixed weights:
  - Even neurons get 0xFF 0xFF, odd neurons get 0x00 0x00; x = 0xFF 0xFF -> RUN returns 0x55.
  - Then LOAD_X 0x00 0x00 and RUN -> 0xAA.
- Backpressure: hold tx_ready=0 for 5 cycles during SEND -> tx_valid stays 1, tx_data is stable, rx_ready=0, busy=1, done stays 0 until the handshake.
- Reset mid-load: after 0x01 and 3 weight bytes assert rst for 1 cycle -> state IDLE. STATUS -> 0x00. A following RUN sets err and produces no tx.
